feed_forward_node_mac: RTL and testbench
========================================

Name: feed_forward_node_mac

Overview:
- Parametrised successor to the fixed 3-input feed-forward node.
- Computes one neuron: o = act(bias + sum over k of data[k]*weight[k]) for NUM_INPUTS FP32 operand pairs.
- Operands stream in serially under a valid/ready handshake; one shared multiplier and one shared adder serve all inputs.
- Sits between the layer weight/activation buffers and the next layer's input FIFO.

Parameters:
- DATA_WIDTH, 32: operand width; IEEE-754 single only.
- NUM_INPUTS, 3: operand pairs per neuron; must be ≥1.
- MUL_LATENCY, 7: multiplier pipeline depth in cycles.
- ADD_LATENCY, 7: adder pipeline depth in cycles.
- LEAKY_SHIFT, 3: negative-slope alpha = 2^-LEAKY_SHIFT.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset; asynchronous, active-high (the name is kept for codebase consistency; asserted = 1).
- i_valid  in  1  operand pair present.
- o_ready  out  1  block can accept an operand pair this cycle.
- i_data  in  DATA_WIDTH  activation operand.
- i_weight  in  DATA_WIDTH  weight operand.
- i_bias  in  DATA_WIDTH  bias; sampled only on the first accept of a neuron.
- o_data  out  DATA_WIDTH  neuron result; held until the next result.
- o_valid  out  1  one-cycle pulse when o_data is updated.
- o_busy  out  1  high from first accept until the o_valid cycle.

Behaviour:
- Reset: all outputs 0, except o_ready = 1. State = IDLE, count = 0, acc = 0. Internal FP units receive the inverted reset.
- Accept: occurs on a cycle with i_valid & o_ready. No accept occurs while o_ready = 0; the upstream side holds its data.
- First accept of a neuron: acc <= i_bias. count runs 0..NUM_INPUTS-1, width $clog2(NUM_INPUTS+1).
- States:
  - IDLE: o_ready = 1. On accept, issue the product and go to MUL_WAIT.
  - MUL_WAIT: wait for the multiplier valid, then issue acc + product to the adder and go to ADD_WAIT.
  - ADD_WAIT: on adder valid, acc <= sum and count++. If count < NUM_INPUTS, go to IDLE; otherwise go to ACT.
  - ACT: compute the activation; register o_data and pulse o_valid. Then count <= 0 and go to IDLE.
- o_ready = 1 only in IDLE. Throughput is one pair per MUL_LATENCY + ADD_LATENCY + 1 cycles.
- Latency: last accept to o_valid is MUL_LATENCY + ADD_LATENCY + 2 cycles (16 at default parameters).
- Activation: sign = 0 passes unchanged.
  - sign = 1: exponent -= LEAKY_SHIFT.
  - If the exponent is ≤ LEAKY_SHIFT (including denormals), the result is signed zero 0x80000000.
  - Negative zero in gives negative zero out.
  - NaN/Inf pass unchanged.
- o_busy falls in the same cycle o_valid pulses. A new neuron may be accepted the cycle after o_valid.
- Reset mid-operation: abort immediately and drop in-flight products. No o_valid is produced.
- NUM_INPUTS = 1: after the first ADD_WAIT, go directly to ACT.

Optional Feature:
- Macro FF_NODE_LEAKY_RELU_EN.
- Defined: ACT applies the leaky ReLU described above.
- Undefined: ACT passes acc unchanged (linear node). Latency is identical, so the output-layer use case keeps the same timing.

Decomposition:
- Shared package holds:
  - FP32 field constants: SIGN_BIT = 31, EXP_MSB = 30, EXP_LSB = 23, MANT_W = 23.
  - FP32_ZERO and FP32_NEG_ZERO.
  - A state enum {IDLE, MUL_WAIT, ADD_WAIT, ACT}.
- Instantiate the codebase FP32 multiplier and 2-input FP32 adder; do not reimplement them.
- One natural sub-module: fp32_leaky_relu_shift, combinational, parameter LEAKY_SHIFT.

Test Plan:
- Sum check: NUM_INPUTS = 3, bias 0, data 1.0, 2.0, 3.0 (0x3F800000, 0x40000000, 0x40400000), weights 1.0. Expect o_data 0x40C00000 (6.0), a single o_valid pulse 16 cycles after the third accept.
- Negative slope: bias 0, data -8.0 (0xC1000000), 0, 0, weights 1.0. With the macro, expect 0xBF800000 (-1.0); without it, expect 0xC1000000.
- Back-pressure: i_valid held high with 6 pairs queued. Expect exactly 3 accepts per neuron, o_ready low 15 cycles after each accept, and two o_valid pulses with correct sums.
- Bias sampling: bias 0.5 (0x3F000000), data 1.0 ×3, weights 1.0. Change i_bias after the first accept. Expect 0x40600000 (3.5).
- Underflow: bias 0, data 0x80800000 (-min normal), 0, 0, weight 1.0. Expect 0x80000000 with the macro.
- Reset mid-operation: assert rst_n during MUL_WAIT of the second pair. Expect o_ready = 1, o_busy = 0, o_data = 0 and no o_valid. The next neuron computes 6.0 correctly.

Source files
------------

// File: rtl/feed_forward_node_mac_pkg.sv
// Shared definitions for the feed-forward node MAC: FP32 field positions,
// signed-zero / quiet-NaN constants and the node controller state encoding.
package feed_forward_node_mac_pkg;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MANT_W   = 23;

    localparam logic [31:0] FP32_ZERO     = 32'h0000_0000;
    localparam logic [31:0] FP32_NEG_ZERO = 32'h8000_0000;
    localparam logic [31:0] FP32_QNAN     = 32'h7FC0_0000;

    typedef enum logic [1:0] {IDLE, MUL_WAIT, ADD_WAIT, ACT} state_t;

endpackage

// File: rtl/fp32_add.sv
// Pipelined 2-input FP32 adder (round-to-nearest-even, denormals flushed).
// Ports: clk, rst_n (async, active-low), i_valid/i_a/i_b issue an operation,
// o_valid/o_result appear LATENCY cycles later.
module fp32_add
    import feed_forward_node_mac_pkg::*;
#(
    parameter int LATENCY = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_valid,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_valid,
    output logic [31:0] o_result
);
    logic [31:0]        fa, fb, a, b, res_d;
    logic [7:0]         ea, eb, d;
    logic [26:0]        ma, mb, mbs;
    logic [27:0]        s;
    logic [24:0]        mr;
    logic [4:0]         lz;
    logic signed [9:0]  e;

    always_comb begin
        fa = (i_a[EXP_MSB:EXP_LSB] == 8'h00) ? {i_a[SIGN_BIT], 31'b0} : i_a;
        fb = (i_b[EXP_MSB:EXP_LSB] == 8'h00) ? {i_b[SIGN_BIT], 31'b0} : i_b;
        // a always holds the larger magnitude, so it also decides the sign
        if (fb[30:0] > fa[30:0]) begin a = fb; b = fa; end
        else                     begin a = fa; b = fb; end
        ea  = a[EXP_MSB:EXP_LSB];
        eb  = b[EXP_MSB:EXP_LSB];
        ma  = {1'b1, a[MANT_W-1:0], 3'b000};
        mb  = {(eb != 8'h00), b[MANT_W-1:0], 3'b000};
        d   = ea - eb;
        // guard/round/sticky alignment: shifted-out bits fold into bit 0
        mbs = (d >= 8'd27) ? {26'b0, |mb}
                           : ((mb >> d) | {26'b0, |(mb & ((27'd1 << d) - 27'd1))});
        if (a[SIGN_BIT] == b[SIGN_BIT]) s = {1'b0, ma} + {1'b0, mbs};
        else                            s = {1'b0, ma} - {1'b0, mbs};
        e  = 10'(ea);
        lz = '0;
        if (s[27]) begin
            s = {1'b0, s[27:2], s[1] | s[0]};
            e = e + 10'sd1;
        end else begin
            for (int i = 0; i < 27; i++) if (s[i]) lz = 5'(26 - i);
            s = s << lz;
            e = e - 10'(lz);
        end
        mr = {1'b0, s[26:3]} + {24'b0, s[2] & ((|s[1:0]) | s[3])};
        if (mr[24]) e = e + 10'sd1;
        if (ea == 8'hFF) begin
            if ((a[MANT_W-1:0] != '0) || ((eb == 8'hFF) && (a[SIGN_BIT] != b[SIGN_BIT])))
                res_d = FP32_QNAN;
            else
                res_d = a;
        end
        else if (ea == 8'h00)   res_d = {a[SIGN_BIT] & b[SIGN_BIT], 31'b0};
        else if (s == '0)       res_d = FP32_ZERO;
        else if (e >= 10'sd255) res_d = {a[SIGN_BIT], 8'hFF, 23'b0};
        else if (e <= 10'sd0)   res_d = {a[SIGN_BIT], 31'b0};
        else                    res_d = {a[SIGN_BIT], e[7:0], mr[24] ? 23'b0 : mr[22:0]};
    end

    logic [LATENCY-1:0] vld_q;
    logic [31:0]        res_q [LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < LATENCY; i++) res_q[i] <= '0;
        end else begin
            vld_q[0] <= i_valid;
            res_q[0] <= res_d;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                res_q[i] <= res_q[i-1];
            end
        end
    end

    assign o_valid  = vld_q[LATENCY-1];
    assign o_result = res_q[LATENCY-1];
endmodule

// File: rtl/fp32_leaky_relu_shift.sv
// Combinational leaky ReLU with alpha = 2^-LEAKY_SHIFT done as an exponent
// decrement. Non-negative values, NaN and Inf pass through; negatives whose
// exponent would fall into the denormal range become -0.
// Ports: i_x operand, o_y activated result.
module fp32_leaky_relu_shift
    import feed_forward_node_mac_pkg::*;
#(
    parameter int LEAKY_SHIFT = 3
) (
    input  logic [31:0] i_x,
    output logic [31:0] o_y
);
    logic [7:0] exp_v;

    always_comb begin
        exp_v = i_x[EXP_MSB:EXP_LSB];
        o_y   = i_x;
        if (i_x[SIGN_BIT] && (exp_v != 8'hFF)) begin
            if (exp_v <= 8'(LEAKY_SHIFT)) o_y = FP32_NEG_ZERO;
            else o_y = {1'b1, exp_v - 8'(LEAKY_SHIFT), i_x[MANT_W-1:0]};
        end
    end
endmodule

// File: rtl/fp32_mul.sv
// Pipelined FP32 multiplier (round-to-nearest-even, denormals flushed to zero).
// Ports: clk, rst_n (async, active-low), i_valid/i_a/i_b issue an operation,
// o_valid/o_result appear LATENCY cycles later.
module fp32_mul
    import feed_forward_node_mac_pkg::*;
#(
    parameter int LATENCY = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_valid,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_valid,
    output logic [31:0] o_result
);
    logic               sgn, g, st, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic [7:0]         ea, eb;
    logic [47:0]        p;
    logic [22:0]        m;
    logic [23:0]        mr;
    logic signed [9:0]  e;
    logic [31:0]        res_d;

    always_comb begin
        sgn    = i_a[SIGN_BIT] ^ i_b[SIGN_BIT];
        ea     = i_a[EXP_MSB:EXP_LSB];
        eb     = i_b[EXP_MSB:EXP_LSB];
        nan_a  = (ea == 8'hFF) && (i_a[MANT_W-1:0] != '0);
        nan_b  = (eb == 8'hFF) && (i_b[MANT_W-1:0] != '0);
        inf_a  = (ea == 8'hFF) && !nan_a;
        inf_b  = (eb == 8'hFF) && !nan_b;
        zero_a = (ea == 8'h00);
        zero_b = (eb == 8'h00);
        p      = {24'b0, 1'b1, i_a[MANT_W-1:0]} * {24'b0, 1'b1, i_b[MANT_W-1:0]};
        e      = 10'(ea) + 10'(eb) - 10'd127;
        if (p[47]) begin
            m  = p[46:24];
            g  = p[23];
            st = |p[22:0];
            e  = e + 10'sd1;
        end else begin
            m  = p[45:23];
            g  = p[22];
            st = |p[21:0];
        end
        mr = {1'b0, m} + {23'b0, g & (st | m[0])};
        if (mr[23]) e = e + 10'sd1;
        if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) res_d = FP32_QNAN;
        else if (inf_a || inf_b)     res_d = {sgn, 8'hFF, 23'b0};
        else if (zero_a || zero_b)   res_d = {sgn, 31'b0};
        else if (e >= 10'sd255)      res_d = {sgn, 8'hFF, 23'b0};
        else if (e <= 10'sd0)        res_d = {sgn, 31'b0};
        else                         res_d = {sgn, e[7:0], mr[22:0]};
    end

    logic [LATENCY-1:0] vld_q;
    logic [31:0]        res_q [LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < LATENCY; i++) res_q[i] <= '0;
        end else begin
            vld_q[0] <= i_valid;
            res_q[0] <= res_d;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                res_q[i] <= res_q[i-1];
            end
        end
    end

    assign o_valid  = vld_q[LATENCY-1];
    assign o_result = res_q[LATENCY-1];
endmodule

// File: rtl/feed_forward_node_mac.sv
// One neuron: o = act(bias + sum data[k]*weight[k]) over NUM_INPUTS serial FP32
// operand pairs, sharing one multiplier and one adder.
// Optional feature macro: FF_NODE_LEAKY_RELU_EN (leaky ReLU output; linear
// pass-through when undefined, with identical latency).
// Ports: clk; rst_n (async, ACTIVE-HIGH despite the name); i_valid/o_ready
// handshake for i_data/i_weight (i_bias sampled on the first accept of a
// neuron); o_data held result, o_valid one-cycle update pulse, o_busy high
// from first accept until the o_valid cycle.
module feed_forward_node_mac
    import feed_forward_node_mac_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_INPUTS  = 3,
    parameter int MUL_LATENCY = 7,
    parameter int ADD_LATENCY = 7,
    parameter int LEAKY_SHIFT = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [DATA_WIDTH-1:0] i_weight,
    input  logic [DATA_WIDTH-1:0] i_bias,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_busy
);
    localparam int CNT_W = $clog2(NUM_INPUTS + 1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d, o_data_q, o_data_d;
    logic                  o_ready_q, o_ready_d, o_valid_q, o_valid_d, o_busy_q, o_busy_d;
    logic                  accept, fp_rst_n, mul_valid, add_issue, add_valid;
    logic [31:0]           mul_res, add_res, act_res;

    assign accept   = i_valid & o_ready_q;
    assign fp_rst_n = ~rst_n;
    // the adder takes the running sum the cycle the product lands
    assign add_issue = (state_q == MUL_WAIT) && mul_valid;

    fp32_mul #(.LATENCY(MUL_LATENCY)) u_mul (
        .clk(clk), .rst_n(fp_rst_n), .i_valid(accept), .i_a(i_data), .i_b(i_weight),
        .o_valid(mul_valid), .o_result(mul_res)
    );

    fp32_add #(.LATENCY(ADD_LATENCY)) u_add (
        .clk(clk), .rst_n(fp_rst_n), .i_valid(add_issue), .i_a(acc_q), .i_b(mul_res),
        .o_valid(add_valid), .o_result(add_res)
    );

`ifdef FF_NODE_LEAKY_RELU_EN
    fp32_leaky_relu_shift #(.LEAKY_SHIFT(LEAKY_SHIFT)) u_act (.i_x(acc_q), .o_y(act_res));
`else
    assign act_res = acc_q;
`endif

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        o_data_d = o_data_q;
        o_valid_d = 1'b0;
        o_busy_d = o_busy_q;
        unique case (state_q)
            IDLE: if (accept) begin
                if (count_q == '0) begin
                    acc_d    = i_bias;
                    o_busy_d = 1'b1;
                end
                state_d = MUL_WAIT;
            end
            MUL_WAIT: if (mul_valid) state_d = ADD_WAIT;
            ADD_WAIT: if (add_valid) begin
                acc_d   = add_res;
                count_d = count_q + CNT_W'(1);
                state_d = (count_d < CNT_W'(NUM_INPUTS)) ? IDLE : ACT;
            end
            ACT: begin
                o_data_d  = act_res;
                o_valid_d = 1'b1;
                o_busy_d  = 1'b0;
                count_d   = '0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        o_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            acc_q     <= FP32_ZERO;
            o_data_q  <= FP32_ZERO;
            o_ready_q <= 1'b1;
            o_valid_q <= 1'b0;
            o_busy_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            o_data_q  <= o_data_d;
            o_ready_q <= o_ready_d;
            o_valid_q <= o_valid_d;
            o_busy_q  <= o_busy_d;
        end
    end

    assign o_ready = o_ready_q;
    assign o_data  = o_data_q;
    assign o_valid = o_valid_q;
    assign o_busy  = o_busy_q;
endmodule

// File: tb/tb_feed_forward_node_mac.sv
module tb_feed_forward_node_mac;
    localparam int N    = 3;
    localparam int LS   = 3;
    localparam int BIG  = 1 << 30;
    localparam int MAXC = 20000;

    logic clk = 1'b0;
    logic rst_n, i_valid, o_ready, o_valid, o_busy;
    logic [31:0] i_data, i_weight, i_bias, o_data;

    always #5 clk = ~clk;

    feed_forward_node_mac #(.DATA_WIDTH(32), .NUM_INPUTS(N), .MUL_LATENCY(7),
                            .ADD_LATENCY(7), .LEAKY_SHIFT(LS)) dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .i_weight(i_weight), .i_bias(i_bias),
        .o_data(o_data), .o_valid(o_valid), .o_busy(o_busy)
    );

    typedef struct packed {
        logic [31:0]          bias;
        logic [N-1:0][31:0]   d;
        logic [N-1:0][31:0]   w;
        logic [31:0]          exp;
        bit                   hold;
        bit                   rst;
    } nrn_t;

    nrn_t q[$];
    int vectors = 0, miscompares = 0;
    int n = 0, ni = 0, k = 0;
    int pend_at = -1, ready_at = 0, busy_lo = BIG, busy_hi = -1, rst_at = -1, rst_cnt = 0;
    logic [31:0] pend_data, hold_data = 32'h0;
    bit prev_acc;

    // exact FP32 encoding of v * 2^-fb (|v| < 2^24)
    function automatic logic [31:0] to_fp32(int v, int fb);
        int m, msb;
        logic [31:0] mant;
        logic [7:0] e;
        if (v == 0) return 32'h0;
        m = (v < 0) ? -v : v;
        msb = 0;
        for (int i = 0; i < 31; i++) if (m[i]) msb = i;
        e = 8'(127 + msb - fb);
        mant = (msb >= 23) ? 32'(m >> (msb - 23)) : 32'(m << (23 - msb));
        return {(v < 0), e, mant[22:0]};
    endfunction

    // activation of a value held in half units
    function automatic logic [31:0] model_act(int sh);
`ifdef FF_NODE_LEAKY_RELU_EN
        if (sh < 0) return to_fp32(sh, 1 + LS);
`endif
        return to_fp32(sh, 1);
    endfunction

    task automatic chk1(string nm, logic act, logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %b expected %b", nm, n, act, exp);
        end
    endtask

    task automatic chk32(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, n, act, exp);
        end
    endtask

    task automatic check_outputs();
        logic ev;
        ev = (n == pend_at);
        chk1("o_valid", o_valid, ev);
        if (ev) begin
            hold_data = pend_data;
            pend_at = -1;
        end
        chk32("o_data", o_data, hold_data);
        chk1("o_ready", o_ready, n >= ready_at);
        chk1("o_busy", o_busy, (n >= busy_lo) && (n <= busy_hi));
    endtask

    task automatic drive();
        if (ni >= q.size()) begin
            i_valid = 1'b0;
        end else if (q[ni].hold || $urandom_range(0, 2) != 0) begin
            i_valid  = 1'b1;
            i_data   = q[ni].d[k];
            i_weight = q[ni].w[k];
            i_bias   = (k == 0) ? q[ni].bias : $urandom;
        end else begin
            i_valid  = 1'b0;
            i_data   = $urandom;
            i_weight = $urandom;
            i_bias   = $urandom;
        end
    endtask

    task automatic model_accept();
        if (k == 0) begin
            busy_lo = n + 1;
            busy_hi = BIG;
        end
        if (k == 1 && q[ni].rst) rst_at = n + 4;
        if (k == N - 1) begin
            ready_at  = n + 16;
            pend_at   = n + 16;
            pend_data = q[ni].exp;
            busy_hi   = n + 15;
            k = 0;
            ni++;
        end else begin
            ready_at = n + 15;
            k++;
        end
    endtask

    task automatic add_dir(logic [31:0] b, logic [31:0] d0, logic [31:0] d1, logic [31:0] d2,
                           logic [31:0] w, logic [31:0] e, bit h, bit r);
        nrn_t x;
        x.bias = b;
        x.d[0] = d0; x.d[1] = d1; x.d[2] = d2;
        x.w[0] = w;  x.w[1] = w;  x.w[2] = w;
        x.exp = e; x.hold = h; x.rst = r;
        q.push_back(x);
    endtask

    initial begin
        nrn_t x;
        int bh, sh, dv, wv;
        rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_weight = '0; i_bias = '0;
        #1 rst_n = 1'b1;

        add_dir(32'h0, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h3F800000, 32'h40C00000, 0, 0);
`ifdef FF_NODE_LEAKY_RELU_EN
        add_dir(32'h0, 32'hC1000000, 32'h0, 32'h0, 32'h3F800000, 32'hBF800000, 0, 0);
`else
        add_dir(32'h0, 32'hC1000000, 32'h0, 32'h0, 32'h3F800000, 32'hC1000000, 0, 0);
`endif
        add_dir(32'h0, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40000000, 32'h41400000, 1, 0);
        add_dir(32'h3F800000, 32'h40800000, 32'h40A00000, 32'h40C00000, 32'h3F800000, 32'h41800000, 1, 0);
        add_dir(32'h3F000000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40600000, 0, 0);
`ifdef FF_NODE_LEAKY_RELU_EN
        add_dir(32'h0, 32'h80800000, 32'h0, 32'h0, 32'h3F800000, 32'h80000000, 0, 0);
`else
        add_dir(32'h0, 32'h80800000, 32'h0, 32'h0, 32'h3F800000, 32'h80800000, 0, 0);
`endif
        add_dir(32'h0, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h3F800000, 32'h40C00000, 0, 1);
        add_dir(32'h0, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h3F800000, 32'h40C00000, 0, 0);

        // random small-integer neurons: every sum is exactly representable
        for (int r = 0; r < 30; r++) begin
            bh = int'($urandom_range(0, 40)) - 20;
            sh = bh;
            for (int j = 0; j < N; j++) begin
                dv = int'($urandom_range(0, 30)) - 15;
                wv = int'($urandom_range(0, 14)) - 7;
                sh += 2 * dv * wv;
                x.d[j] = to_fp32(dv, 0);
                x.w[j] = to_fp32(wv, 0);
            end
            x.bias = to_fp32(bh, 1);
            x.exp  = model_act(sh);
            x.hold = ($urandom_range(0, 4) == 0);
            x.rst  = 1'b0;
            q.push_back(x);
        end

        repeat (2) begin
            @(negedge clk); n++;
            check_outputs();
        end
        rst_n = 1'b0;
        prev_acc = 1'b1;

        while (1) begin
            @(negedge clk); n++;
            check_outputs();
            if (n >= MAXC) begin
                miscompares++;
                $display("FAIL timeout cycle %0d: got %0d neurons done expected %0d", n, ni, q.size());
                break;
            end
            if (rst_cnt > 0) begin
                rst_cnt--;
                if (rst_cnt != 0) continue;
                rst_n = 1'b0;
                prev_acc = 1'b1;
            end else if (n == rst_at) begin
                rst_n = 1'b1;
                i_valid = 1'b0;
                rst_cnt = 2;
                rst_at = -1;
                ready_at = 0; pend_at = -1; hold_data = 32'h0; busy_lo = BIG; busy_hi = -1;
                if (k != 0) begin ni++; k = 0; end
                continue;
            end
            if (ni >= q.size() && pend_at < 0) break;
            if (prev_acc || !i_valid) drive();
            prev_acc = i_valid && o_ready;
            if (prev_acc) model_accept();
        end

        i_valid = 1'b0;
        repeat (20) begin
            @(negedge clk); n++;
            check_outputs();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
